// File: rtl/path_reader_pkg.sv
// ============================================================================
// Module  : path_reader_pkg
// Brief   : Shared types and constants for the path_reader stack drain block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package path_reader_pkg;

    localparam int c_coord_w       = 4;
    localparam int c_default_depth = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        EMIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/path_buf.sv
// ============================================================================
// Module  : path_buf
// Brief   : DEPTH x 2W register file, one synchronous write port and one
//           combinational read port; storage is not reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module path_buf #(
    parameter int DEPTH = 16,
    parameter int W     = 4,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [2*W-1:0]  i_wdata,
    input  logic [AW-1:0]   i_raddr,
    output logic [2*W-1:0]  o_rdata
);

    logic [2*W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/path_reader.sv
// ============================================================================
// Module  : path_reader
// Brief   : Pops the coordinate stack into a buffer, then streams the path out
//           in push order over valid/ready. PATH_READER_LEN_EN adds path_len.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module path_reader
    import path_reader_pkg::*;
#(
    parameter int DEPTH = c_default_depth,
    parameter int W     = c_coord_w
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         stk_pop,
    input  logic [W-1:0] stk_x,
    input  logic [W-1:0] stk_y,
    input  logic         stk_fail,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_x,
    output logic [W-1:0] out_y,
    output logic         out_last,
    output logic         busy,
    output logic         done
`ifdef PATH_READER_LEN_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] path_len
`endif
);

    localparam int c_cw = $clog2(DEPTH + 1);
    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);

    state_t          r_state;
    state_t          w_next;
    logic [c_cw-1:0] r_cnt;
    logic [c_aw-1:0] r_idx;
    logic            w_pop;
    logic            w_fire;
    logic [2*W-1:0]  w_rdata;

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = DRAIN;
            end
            DRAIN: begin
                w_pop = !stk_fail && (r_cnt < c_full);
                // Stack exhausted or buffer full: an empty path skips EMIT
                if (!w_pop) w_next = (r_cnt != '0) ? EMIT : FINISH;
            end
            EMIT: begin
                if (out_ready && (r_idx == '0)) w_next = FINISH;
            end
            FINISH: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign stk_pop   = w_pop && !rst;
    assign out_valid = (r_state == EMIT);
    assign w_fire    = out_valid && out_ready;
    assign out_last  = out_valid && (r_idx == '0);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == FINISH);
    assign out_x     = w_rdata[2*W-1:W];
    assign out_y     = w_rdata[W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start) r_cnt <= '0;
                end
                DRAIN: begin
                    if (w_pop) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (r_cnt != '0) begin
                        r_idx <= c_aw'(r_cnt - 1'b1);
                    end
                end
                EMIT: begin
                    if (w_fire && (r_idx != '0)) r_idx <= r_idx - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PATH_READER_LEN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            path_len <= '0;
        end else if ((r_state == DRAIN) && !w_pop) begin
            path_len <= r_cnt;
        end
    end
`endif

    path_buf #(
        .DEPTH (DEPTH),
        .W     (W),
        .AW    (c_aw)
    ) u_buf (
        .clk     (clk),
        .i_we    (stk_pop),
        .i_waddr (r_cnt[c_aw-1:0]),
        .i_wdata ({stk_x, stk_y}),
        .i_raddr (r_idx),
        .o_rdata (w_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_path_reader.sv
// ============================================================================
// Module  : tb_path_reader
// Brief   : Randomised bench for path_reader with a queue-based stack and a
//           push-order reference of the expected path stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_path_reader;

    localparam int DEPTH = 16;
    localparam int W     = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stk_pop;
    logic [W-1:0] stk_x = '0;
    logic [W-1:0] stk_y = '0;
    logic         stk_fail = 1'b1;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_x;
    logic [W-1:0] out_y;
    logic         out_last;
    logic         busy;
    logic         done;
`ifdef PATH_READER_LEN_EN
    logic [$clog2(DEPTH+1)-1:0] path_len;
`endif

    always #5 clk = ~clk;

    path_reader #(.DEPTH(DEPTH), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stk_pop   (stk_pop),
        .stk_x     (stk_x),
        .stk_y     (stk_y),
        .stk_fail  (stk_fail),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef PATH_READER_LEN_EN
        ,
        .path_len  (path_len)
`endif
    );

    // Stack model: back of the queue is the top of the stack
    logic [2*W-1:0] stack_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    bit  pend_pop = 1'b0;
    bit  drv_start = 1'b0;
    bit  drv_ready = 1'b1;
    bit  drv_rst   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_stack();
        stk_fail = (stack_q.size() == 0);
        if (stack_q.size() != 0) {stk_x, stk_y} = stack_q[$];
    endtask

    task automatic push(input logic [W-1:0] x, input logic [W-1:0] y);
        stack_q.push_back({x, y});
        refresh_stack();
    endtask

    task automatic clear_stack();
        stack_q.delete();
        refresh_stack();
    endtask

    // One clock: retire the previous edge's pop, apply inputs, settle, sample
    task automatic step();
        @(negedge clk);
        if (pend_pop && stack_q.size() != 0) void'(stack_q.pop_back());
        refresh_stack();
        start     = drv_start;
        out_ready = drv_ready;
        rst       = drv_rst;
        #1;
        pend_pop = stk_pop;
    endtask

    // ready_mode: 0 = always ready, 1 = fixed 1,0,0,1,0,1 pattern, 2 = random
    task automatic run_path(input int ready_mode, input bit start_in_emit, input string name);
        logic [2*W-1:0] exp_q[$];
        logic [2*W-1:0] prev_data;
        logic [2*W-1:0] exp_d;
        bit   pattern[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bit   prev_stall = 1'b0;
        bit   prev_valid = 1'b0;
        bit   sent_start = 1'b0;
        int   n = stack_q.size();
        int   k = (n < DEPTH) ? n : DEPTH;
        int   pops = 0, outs = 0, dones = 0, done_cyc = -1;

        for (int i = n - k; i < n; i++) exp_q.push_back(stack_q[i]);

        drv_start = 1'b1;
        drv_ready = 1'b1;
        step();
        drv_start = 1'b0;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            case (ready_mode)
                0:       drv_ready = 1'b1;
                1:       drv_ready = pattern[(cyc - 1) % 6];
                default: drv_ready = 1'($urandom_range(0, 1));
            endcase
            drv_start = start_in_emit && prev_valid && !sent_start;
            if (drv_start) sent_start = 1'b1;
            step();
            if (stk_pop) pops++;
            if (prev_stall) begin
                check_eq({name, "_hold_valid"}, out_valid, 1'b1);
                check_eq({name, "_hold_data"}, {out_x, out_y}, prev_data);
            end
            if (out_valid && out_ready) begin
                exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                check_eq({name, "_data"}, {out_x, out_y}, exp_d);
                check_eq({name, "_last"}, out_last, (outs == k - 1));
                outs++;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_valid = out_valid;
            prev_data  = {out_x, out_y};
        end
        drv_start = 1'b0;
        drv_ready = 1'b1;

        check_eq({name, "_pops"}, pops, k);
        check_eq({name, "_outs"}, outs, k);
        check_eq({name, "_dones"}, dones, 1);
        check_eq({name, "_left"}, stack_q.size(), n - k);
        check_eq({name, "_fail_after"}, stk_fail, (n - k == 0));
        check_eq({name, "_busy_after"}, busy, 1'b0);
        if (ready_mode == 0) check_eq({name, "_done_cyc"}, done_cyc, 2 * k + 2);
`ifdef PATH_READER_LEN_EN
        check_eq({name, "_path_len"}, path_len, k);
`endif
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) push(W'($urandom), W'($urandom));
    endtask

    initial begin
        drv_rst = 1'b1;
        repeat (3) step();
        check_eq("rst_pop", stk_pop, 1'b0);
        drv_rst = 1'b0;
        step();
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_valid", out_valid, 1'b0);
        check_eq("reset_last", out_last, 1'b0);
        check_eq("reset_done", done, 1'b0);
        check_eq("reset_pop", stk_pop, 1'b0);
`ifdef PATH_READER_LEN_EN
        check_eq("reset_path_len", path_len, 0);
`endif

        clear_stack();
        push(4'd1, 4'd0);
        push(4'd1, 4'd1);
        push(4'd2, 4'd1);
        run_path(0, 1'b0, "basic3");

        clear_stack();
        run_path(0, 1'b0, "empty");

        clear_stack();
        push_random(3);
        run_path(1, 1'b0, "toggle3");

        clear_stack();
        push_random(18);
        run_path(0, 1'b0, "over18");

        // Reset on the second DRAIN cycle, then drain what is left
        clear_stack();
        push_random(5);
        drv_start = 1'b1;
        step();
        drv_start = 1'b0;
        step();
        check_eq("mid_drain1_pop", stk_pop, 1'b1);
        drv_rst = 1'b1;
        step();
        check_eq("mid_rst_pop", stk_pop, 1'b0);
        drv_rst = 1'b0;
        step();
        check_eq("mid_rst_idle", busy, 1'b0);
        check_eq("mid_rst_left", stack_q.size(), 4);
        run_path(0, 1'b0, "after_rst");

        clear_stack();
        push_random(5);
        run_path(0, 1'b1, "start_in_emit");

        for (int r = 0; r < 8; r++) begin
            clear_stack();
            push_random($urandom_range(0, 20));
            run_path(2, 1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/path_reader.md
# path_reader

Drains the coordinate stack after the maze solver finishes and streams the stored path out in push order, first cell pushed first. It is the read-side controller for the stack: it issues pops, captures each popped (x, y) pair into a local buffer, then replays the buffer in reverse over a valid/ready stream. It sits between the stack and the path display/output logic.

## Interface
- `DEPTH`, 16: maximum number of path entries buffered; must match the stack depth.
- `W`, 4: width of each coordinate.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request to begin a drain; honoured only in IDLE.
- `stk_pop`  out  1: pop strobe to the stack; the stack removes its top entry on the next rising edge.
- `stk_x`  in  W: stack top x coordinate (stack `xOut`), valid combinationally while the stack is non-empty.
- `stk_y`  in  W: stack top y coordinate (stack `yOut`).
- `stk_fail`  in  1: stack `fail`; high when the stack holds no entries.
- `out_valid`  out  1: output pair valid.
- `out_ready`  in  1: downstream accepts the pair when high with `out_valid`.
- `out_x`, `out_y`  out  W: output coordinates.
- `out_last`  out  1: high with the final pair of a path.
- `busy`  out  1: high in any state except IDLE.
- `done`  out  1: one-cycle pulse when a path completes (including empty paths).

## Operation
- States: IDLE, DRAIN, EMIT, FINISH.
- IDLE: `busy`=0. On `start`=1 → DRAIN, `cnt` cleared to 0.
- DRAIN: `stk_pop` = !`stk_fail` && `cnt` < DEPTH (combinational). When it is 1, on the edge {`stk_x`,`stk_y`} is written to `buf[cnt]` and `cnt` increments. When `stk_fail`=1 or `cnt`=DEPTH: go to EMIT if `cnt`>0, otherwise FINISH. `buf[0]` is the goal end (last pushed); `buf[cnt-1]` is the start cell.
- EMIT: `idx` loaded with `cnt-1` on entry. `out_valid`=1 and `out_x`/`out_y` = `buf[idx]`. On `out_valid`&&`out_ready`: if `idx`=0 → FINISH, else `idx` decrements. `out_last` = (`idx`=0).
- FINISH: `done`=1 for exactly one cycle, then IDLE.
- If `cnt` reaches DEPTH and `stk_fail` is still 0, the remaining entries stay in the stack and are not popped. Only DEPTH entries are emitted.
- `start` outside IDLE is ignored, and a second drain is not queued.
- Data presented under `out_valid` holds stable until accepted. `out_valid` is never withdrawn without a handshake.

## Timing
- Reset values: state IDLE, `cnt`=0, `idx`=0. Outputs `stk_pop`, `out_valid`, `out_last`, `busy` and `done` are 0. `out_x`/`out_y` are don't-care but driven from `buf[0]`; buffer contents are not reset.
- `rst` overrides all other inputs in the same cycle, and `stk_pop` is forced to 0 during the `rst` cycle. Reset mid-DRAIN leaves the entries already popped lost; the stack is not restored.
- N-entry path: `start` edge → DRAIN. This is followed by N pop cycles and one cycle to detect `stk_fail` (N+1 DRAIN cycles when N<DEPTH), then EMIT. With `out_ready` held at 1, EMIT takes N cycles, followed by 1 FINISH cycle.
- Empty stack: IDLE → DRAIN (1 cycle, no pop) → FINISH (`done`) → IDLE. `out_valid` never rises.
- Pops are one per cycle, back-to-back. `stk_x`/`stk_y` are sampled in the same cycle `stk_pop` is high.

## Configuration
- `PATH_READER_LEN_EN` defined: adds output `path_len` (width clog2(DEPTH+1)) holding `cnt`. It is registered on leaving DRAIN, reset to 0, and held until the next drain completes.
- `PATH_READER_LEN_EN` undefined: port absent. There is no other behavioural difference.

## Structure
- Package `path_reader_pkg`: state enum (IDLE/DRAIN/EMIT/FINISH), coordinate width constant (4), default depth constant (16).
- Sub-module `path_buf`: DEPTH×2W register file with one synchronous write port and one combinational read port. There is no reset on storage.
- Top holds the FSM, `cnt`/`idx` counters and handshake logic.

## Test plan
- Push (1,0),(1,1),(2,1) into the stack, pulse `start`, hold `out_ready`=1 → `stk_pop` high for 3 consecutive cycles. Outputs are (1,0),(1,1),(2,1) in that order, `out_last` is high on (2,1), and `done` pulses once.
- Empty stack, pulse `start` → no `stk_pop`, no `out_valid`, `done` 2 cycles after `start`.
- 3-entry path with `out_ready` toggling 1,0,0,1,0,1 → each pair is held stable while stalled, and exactly 3 handshakes occur in order.
- Stack holding 18 entries with DEPTH=16 → exactly 16 pops, 16 outputs, and `stk_fail` still 0 afterward. With `PATH_READER_LEN_EN`, `path_len`=16.
- Assert `rst` on the 2nd DRAIN cycle → next cycle is IDLE and `stk_pop`=0 during `rst`. A subsequent `start` drains the remaining entries correctly.
- `start` pulsed during EMIT → ignored: a single `done` pulse and no re-drain.
